// File: rtl/fpga_robots_game_serial_tx.sv
// Host-link transmitter: byte FIFO feeding an async serializer paced by baud1 (8N1 or 8E1).
// Optional parity bit enabled by defining FPGA_ROBOTS_SERTX_PARITY_EN.
module fpga_robots_game_serial_tx #(
    parameter int FIFO_AW = 3
) (
    input  logic       clk,
    input  logic       rst,
    input  logic       baud1,
    input  logic [7:0] i_dat,
    input  logic       i_stb,
    output logic       o_rdy,
    output logic       serial_tx,
    output logic       o_busy
);

    localparam int DEPTH = 2 ** FIFO_AW;
    localparam logic [FIFO_AW:0]   CNT_ZERO = (FIFO_AW + 1)'(1'b0);
    localparam logic [FIFO_AW:0]   CNT_ONE  = (FIFO_AW + 1)'(1'b1);
    localparam logic [FIFO_AW:0]   CNT_FULL = (FIFO_AW + 1)'(DEPTH);
    localparam logic [FIFO_AW-1:0] PTR_ONE  = FIFO_AW'(1'b1);

    typedef enum logic [2:0] {
        ST_IDLE   = 3'd0,
        ST_START  = 3'd1,
        ST_DATA   = 3'd2,
        ST_PARITY = 3'd3,
        ST_STOP   = 3'd4
    } state_t;

`ifdef FPGA_ROBOTS_SERTX_PARITY_EN
    function automatic logic even_parity(input logic [7:0] d);
        return ^d;
    endfunction
`endif

    logic [7:0]         mem_r [DEPTH];
    logic [FIFO_AW-1:0] wr_ptr_r;
    logic [FIFO_AW-1:0] rd_ptr_r;
    logic [FIFO_AW:0]   count_r;
    logic [FIFO_AW:0]   count_next_s;
    state_t             state_r;
    state_t             state_next_s;
    logic [2:0]         bit_r;
    logic [2:0]         bit_next_s;
    logic [7:0]         shreg_r;
    logic [7:0]         shreg_next_s;
    logic               push_s;
    logic               pop_s;
    logic               tx_next_s;

    // Next-state, FIFO pop and next line level; state only moves on a baud1 strobe.
    always_comb begin
        push_s       = i_stb && o_rdy;
        pop_s        = 1'b0;
        state_next_s = state_r;
        bit_next_s   = bit_r;
        shreg_next_s = shreg_r;
        if (baud1) begin
            case (state_r)
                ST_IDLE: begin
                    if (count_r != CNT_ZERO) begin
                        pop_s        = 1'b1;
                        shreg_next_s = mem_r[rd_ptr_r];
                        state_next_s = ST_START;
                    end else begin
                        state_next_s = ST_IDLE;
                    end
                end
                ST_START: begin
                    state_next_s = ST_DATA;
                    bit_next_s   = 3'd0;
                end
                ST_DATA: begin
                    if (bit_r == 3'd7) begin
`ifdef FPGA_ROBOTS_SERTX_PARITY_EN
                        state_next_s = ST_PARITY;
`else
                        state_next_s = ST_STOP;
`endif
                    end else begin
                        bit_next_s = bit_r + 3'd1;
                    end
                end
                ST_PARITY: state_next_s = ST_STOP;
                ST_STOP: begin
                    // Back-to-back frames: the next start bit follows the stop bit directly.
                    if (count_r != CNT_ZERO) begin
                        pop_s        = 1'b1;
                        shreg_next_s = mem_r[rd_ptr_r];
                        state_next_s = ST_START;
                    end else begin
                        state_next_s = ST_IDLE;
                    end
                end
                default: state_next_s = ST_IDLE;
            endcase
        end else begin
            state_next_s = state_r;
        end

        case ({push_s, pop_s})
            2'b10:   count_next_s = count_r + CNT_ONE;
            2'b01:   count_next_s = count_r - CNT_ONE;
            default: count_next_s = count_r;
        endcase

        case (state_next_s)
            ST_IDLE:   tx_next_s = 1'b1;
            ST_START:  tx_next_s = 1'b0;
            ST_DATA:   tx_next_s = shreg_next_s[bit_next_s];
`ifdef FPGA_ROBOTS_SERTX_PARITY_EN
            ST_PARITY: tx_next_s = even_parity(shreg_next_s);
`endif
            ST_STOP:   tx_next_s = 1'b1;
            default:   tx_next_s = 1'b1;
        endcase
    end

    // FIFO storage; contents need no reset because the pointers and count are cleared.
    always_ff @(posedge clk) begin
        if (push_s && !rst) begin
            mem_r[wr_ptr_r] <= i_dat;
        end
    end

    // Control state and registered outputs.
    always_ff @(posedge clk) begin
        if (rst) begin
            wr_ptr_r  <= '0;
            rd_ptr_r  <= '0;
            count_r   <= CNT_ZERO;
            state_r   <= ST_IDLE;
            bit_r     <= 3'd0;
            shreg_r   <= 8'h00;
            serial_tx <= 1'b1;
            o_busy    <= 1'b0;
            o_rdy     <= 1'b0;
        end else begin
            if (push_s) begin
                wr_ptr_r <= wr_ptr_r + PTR_ONE;
            end
            if (pop_s) begin
                rd_ptr_r <= rd_ptr_r + PTR_ONE;
            end
            count_r   <= count_next_s;
            state_r   <= state_next_s;
            bit_r     <= bit_next_s;
            shreg_r   <= shreg_next_s;
            serial_tx <= tx_next_s;
            o_busy    <= (state_next_s != ST_IDLE) || (count_next_s != CNT_ZERO);
            o_rdy     <= (count_next_s != CNT_FULL);
        end
    end

endmodule

// File: tb/tb_fpga_robots_game_serial_tx.sv
// Directed self-checking bench for fpga_robots_game_serial_tx.
// Frame length follows FPGA_ROBOTS_SERTX_PARITY_EN when the bench is built with it.
module tb_fpga_robots_game_serial_tx;

`ifdef FPGA_ROBOTS_SERTX_PARITY_EN
    localparam int NBITS = 11;
`else
    localparam int NBITS = 10;
`endif

    logic       clk = 1'b0;
    logic       rst = 1'b1;
    logic       baud1 = 1'b0;
    logic [7:0] i_dat = 8'h00;
    logic       i_stb = 1'b1;
    logic       o_rdy;
    logic       serial_tx;
    logic       o_busy;

    int         checks = 0;
    int         failures = 0;
    int         baud_mode = 0;   // 0: held low, 1: every 16 clk, 2: tied high
    logic [3:0] baud_div = 4'd0;

    fpga_robots_game_serial_tx #(.FIFO_AW(3)) dut (
        .clk       (clk),
        .rst       (rst),
        .baud1     (baud1),
        .i_dat     (i_dat),
        .i_stb     (i_stb),
        .o_rdy     (o_rdy),
        .serial_tx (serial_tx),
        .o_busy    (o_busy)
    );

    always #5 clk = ~clk;

    // Bit-time strobe generator
    always @(posedge clk) begin
        #1;
        if (baud_mode == 2) begin
            baud1 = 1'b1;
        end else if (baud_mode == 1) begin
            baud_div = baud_div + 4'd1;
            baud1 = (baud_div == 4'd15);
        end else begin
            baud1 = 1'b0;
        end
    end

    task automatic check_val(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        if (obs !== exp) begin
            failures++;
            $display("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic push(input logic [7:0] b);
        i_stb = 1'b1;
        i_dat = b;
        tick();
        i_stb = 1'b0;
    endtask

    // Wait for a start bit, then check every bit of the frame for its full duration.
    task automatic expect_frame(input logic [7:0] b, input int bclk, input int bound, output int waited);
        logic [10:0] exp_bits;
        logic        obs;
        exp_bits[0] = 1'b0;
        for (int i = 0; i < 8; i++) exp_bits[i+1] = b[i];
`ifdef FPGA_ROBOTS_SERTX_PARITY_EN
        exp_bits[9]  = ^b;
        exp_bits[10] = 1'b1;
`else
        exp_bits[9]  = 1'b1;
        exp_bits[10] = 1'b1;
`endif
        waited = 0;
        while (serial_tx !== 1'b0 && waited < bound) begin
            tick();
            waited++;
        end
        if (serial_tx !== 1'b0) begin
            check_val($sformatf("start_timeout_%02h", b), {31'd0, serial_tx}, 32'd0);
        end else begin
            for (int k = 0; k < NBITS; k++) begin
                obs = serial_tx;
                for (int c = 0; c < bclk; c++) begin
                    if (serial_tx !== exp_bits[k]) obs = serial_tx;
                    tick();
                end
                check_val($sformatf("frame_%02h_bit%0d", b, k), {31'd0, obs}, {31'd0, exp_bits[k]});
            end
        end
    endtask

    initial begin
        int w;
        int acc;
        int lows;

        // 1: reset held with i_stb asserted
        for (int i = 0; i < 5; i++) begin
            tick();
            check_val("rst_tx", {31'd0, serial_tx}, 32'd1);
            check_val("rst_busy", {31'd0, o_busy}, 32'd0);
            check_val("rst_rdy", {31'd0, o_rdy}, 32'd0);
        end
        rst = 1'b0;
        i_stb = 1'b0;
        tick();
        check_val("rdy_after_rst", {31'd0, o_rdy}, 32'd1);
        check_val("empty_after_rst", {31'd0, o_busy}, 32'd0);

        // 2: single 0xA5 frame at 16 clk per bit
        baud_mode = 1;
        tick();
        push(8'hA5);
        check_val("busy_after_push", {31'd0, o_busy}, 32'd1);
        expect_frame(8'hA5, 16, 40, w);
        check_val("busy_end_a5", {31'd0, o_busy}, 32'd0);

        // 3: fill the FIFO with baud1 held low, then drain back-to-back
        baud_mode = 0;
        tick();
        tick();
        acc = 0;
        for (int i = 0; i < 9; i++) begin
            i_stb = 1'b1;
            i_dat = 8'(i);
            if (o_rdy === 1'b1) acc++;
            tick();
        end
        i_stb = 1'b0;
        check_val("fill_accepts", acc, 32'd8);
        check_val("full_rdy", {31'd0, o_rdy}, 32'd0);
        baud_mode = 1;
        for (int i = 0; i < 8; i++) begin
            expect_frame(8'(i), 16, 40, w);
            if (i > 0) check_val($sformatf("gap_%0d", i), w, 32'd0);
        end
        check_val("busy_end_fill", {31'd0, o_busy}, 32'd0);
        check_val("rdy_after_drain", {31'd0, o_rdy}, 32'd1);

        // 4: reset during D3 of a 0xFF frame with another byte queued
        push(8'hFF);
        push(8'h12);
        w = 0;
        while (serial_tx !== 1'b0 && w < 40) begin
            tick();
            w++;
        end
        check_val("rst_frame_start", {31'd0, serial_tx}, 32'd0);
        for (int i = 0; i < 69; i++) tick();
        rst = 1'b1;
        tick();
        rst = 1'b0;
        check_val("midrst_tx", {31'd0, serial_tx}, 32'd1);
        check_val("midrst_busy", {31'd0, o_busy}, 32'd0);
        check_val("midrst_rdy", {31'd0, o_rdy}, 32'd0);
        tick();
        check_val("midrst_rdy_rise", {31'd0, o_rdy}, 32'd1);
        lows = 0;
        for (int i = 0; i < 200; i++) begin
            if (serial_tx !== 1'b1) lows++;
            tick();
        end
        check_val("no_frame_after_rst", lows, 32'd0);
        check_val("flushed_busy", {31'd0, o_busy}, 32'd0);

        // 5: baud1 tied high, push coincides with pop
        baud_mode = 2;
        tick();
        tick();
        i_stb = 1'b1;
        i_dat = 8'h11;
        tick();
        i_dat = 8'h3C;
        tick();
        i_stb = 1'b0;
        check_val("pushpop_count", {28'd0, dut.count_r}, 32'd1);
        expect_frame(8'h11, 1, 4, w);
        expect_frame(8'h3C, 1, 4, w);
        check_val("fast_gap", w, 32'd0);
        check_val("busy_end_fast", {31'd0, o_busy}, 32'd0);

        // 6: 0x07 frame length with or without parity
        baud_mode = 1;
        tick();
        push(8'h07);
        expect_frame(8'h07, 16, 40, w);
        check_val("busy_end_07", {31'd0, o_busy}, 32'd0);
        check_val("idle_after_07", {31'd0, serial_tx}, 32'd1);

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
